// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The ROM-Flash window is identified by address[31:20] == ROM_TAG.
package fetch_pkg;

   localparam logic [31:0] ROM_BASE   = 32'h0800_0000;
   localparam logic [11:0] ROM_TAG    = 12'h080;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: registered head, zero-cycle pop; push while full is prevented upstream by credits.
// Flush has priority over push and pop and empties the queue at the clock edge.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   head_valid,
   output fetch_entry_t           head_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_ok;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop_ok   = pop && (count_q != '0);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign occupancy  = count_q;
   assign head_valid = (count_q != '0);
   assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited ROM issue (1-cycle ROM latency), prefetch FIFO to decode.
// First instr_valid 2 cycles after reset/branch; decode backpressure stalls issue via credits.
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = fetch_pkg::ROM_BASE,
   parameter logic [11:0] ROM_TAG      = fetch_pkg::ROM_TAG,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic [31:0] rom_address,
   output logic        rom_write_enable,
   input  logic [31:0] rom_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        fetch_fault
);

   import fetch_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      last_addr_q, last_addr_d;
   logic             inflight_q, inflight_d;
   logic [31:0]      inflight_pc_q, inflight_pc_d;
   logic             fault_q, fault_d;

   logic [CNT_W-1:0] fifo_occ;
   logic             credit_ok;
   logic             tag_ok;
   logic             issue;
   logic             fifo_push;
   fetch_entry_t     fifo_push_data;
   fetch_entry_t     fifo_head;

   // In-flight fetches count against capacity, so a returning word always has a slot.
   assign credit_ok = (32'(fifo_occ) + 32'(inflight_q)) < 32'(FIFO_DEPTH);
   assign tag_ok    = (pc_q[31:20] == ROM_TAG);
   assign issue     = !fault_q && credit_ok && tag_ok;

   assign fifo_push      = inflight_q && !branch_valid;
   assign fifo_push_data = '{pc: inflight_pc_q, instr: rom_data};

   always_comb begin
      pc_d          = pc_q;
      last_addr_d   = last_addr_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      fault_d       = fault_q;
      if (issue) begin
         last_addr_d = pc_q;
      end
      if (branch_valid) begin
         pc_d    = word_align(branch_target);
         fault_d = 1'b0;
      end else if (issue) begin
         inflight_d    = 1'b1;
         inflight_pc_d = pc_q;
         pc_d          = pc_q + WORD_BYTES;
      end else if (!fault_q && credit_ok && !tag_ok) begin
         fault_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q          <= word_align(RESET_VECTOR);
         last_addr_q   <= word_align(RESET_VECTOR);
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         fault_q       <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         last_addr_q   <= last_addr_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         fault_q       <= fault_d;
      end
   end

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (instr_ready),
      .flush     (branch_valid),
      .occupancy (fifo_occ),
      .head_valid(instr_valid),
      .head_data (fifo_head)
   );

   assign rom_address      = issue ? pc_q : last_addr_q;
   assign rom_write_enable = 1'b0;
   assign instr            = fifo_head.instr;
   assign instr_pc         = fifo_head.pc;
   assign fetch_fault      = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: stream model checked every cycle plus directed scenario checks.
module tb_fetch_unit;

   localparam logic [31:0] RV  = 32'h0800_0000;
   localparam logic [11:0] TAG = 12'h080;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        branch_valid = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] rom_address;
   logic        rom_write_enable;
   logic [31:0] rom_data = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        fetch_fault;

   int n_cmp = 0;
   int n_fail = 0;

   fetch_unit dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .branch_valid    (branch_valid),
      .branch_target   (branch_target),
      .rom_address     (rom_address),
      .rom_write_enable(rom_write_enable),
      .rom_data        (rom_data),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .fetch_fault     (fetch_fault)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'hE000_0000 + ({12'h000, a[19:0]} >> 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ROM-Flash with one cycle read latency
   always @(posedge clock) rom_data <= rom_word(rom_address);

   // Stream model: next expected delivered PC and edges since the last restart
   logic [31:0] exp_pc = RV;
   int          age = 0;
   logic        pop_seen = 1'b0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         exp_pc = RV;
         age    = 0;
      end else if (branch_valid) begin
         exp_pc = {branch_target[31:2], 2'b00};
         age    = 0;
      end else begin
         if (pop_seen) exp_pc = exp_pc + 32'd4;
         if (age < 100) age++;
      end
   end

   always @(negedge clock) begin
      chk("rom_we", 32'(rom_write_enable), 32'd0);
      chk("addr_align", 32'(rom_address[1:0]), 32'd0);
      if (!reset_n) begin
         chk("valid_in_reset", 32'(instr_valid), 32'd0);
      end else begin
         if (age < 2) chk("valid_gap", 32'(instr_valid), 32'd0);
         else if (age == 2) chk("valid_first", 32'(instr_valid), 32'd1);
         if (exp_pc[31:20] != TAG) chk("valid_outside", 32'(instr_valid), 32'd0);
         if (instr_valid) begin
            chk("stream_pc", instr_pc, exp_pc);
            chk("stream_instr", instr, rom_word(exp_pc));
         end
      end
      pop_seen = reset_n && instr_valid && instr_ready;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_branch(input logic [31:0] tgt);
      tick();
      branch_valid  = 1'b1;
      branch_target = tgt;
      tick();
      branch_valid  = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_addr", rom_address, RV);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", instr_pc, 32'd0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);

      // sequential fetch with decode always ready
      tick();
      reset_n = 1'b1;
      @(negedge clock); chk("issue0", rom_address, 32'h0800_0000);
      @(negedge clock); chk("issue1", rom_address, 32'h0800_0004);
      @(negedge clock);
      chk("first_valid", 32'(instr_valid), 32'd1);
      chk("first_pc", instr_pc, 32'h0800_0000);
      chk("first_instr", instr, 32'hE000_0000);
      chk("issue2", rom_address, 32'h0800_0008);
      @(negedge clock);
      chk("second_pc", instr_pc, 32'h0800_0004);
      chk("second_instr", instr, 32'hE000_0001);
      repeat (6) @(negedge clock);

      // decode stalled from reset: FIFO fills to capacity
      tick();
      reset_n = 1'b0;
      instr_ready = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (10) @(negedge clock);
      chk("stall_addr", rom_address, 32'h0800_000C);
      chk("stall_occ", 32'(dut.fifo_occ), 32'd4);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_head", instr_pc, 32'h0800_0000);
      tick();
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("drain_pc", instr_pc, 32'h0800_0000 + 32'(4 * i));
      end

      // branch with three buffered entries and one fetch in flight
      tick();
      reset_n = 1'b0;
      instr_ready = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (4) tick();
      chk("br_occ", 32'(dut.fifo_occ), 32'd3);
      chk("br_inflight", 32'(dut.inflight_q), 32'd1);
      branch_valid  = 1'b1;
      branch_target = 32'h0800_0102;
      instr_ready   = 1'b1;
      tick();
      branch_valid = 1'b0;
      @(negedge clock);
      chk("br_gap0", 32'(instr_valid), 32'd0);
      chk("br_flush_occ", 32'(dut.fifo_occ), 32'd0);
      @(negedge clock); chk("br_gap1", 32'(instr_valid), 32'd0);
      @(negedge clock);
      chk("br_first_valid", 32'(instr_valid), 32'd1);
      chk("br_first_pc", instr_pc, 32'h0800_0100);
      chk("br_first_instr", instr, 32'hE000_0040);

      // branch coincident with a pop and a push
      repeat (3) @(negedge clock);
      tick();
      chk("bp_pop_pending", 32'(instr_valid), 32'd1);
      chk("bp_push_pending", 32'(dut.inflight_q), 32'd1);
      branch_valid  = 1'b1;
      branch_target = 32'h0800_0000;
      tick();
      branch_valid = 1'b0;
      @(negedge clock);
      chk("bp_occ", 32'(dut.fifo_occ), 32'd0);
      chk("bp_valid", 32'(instr_valid), 32'd0);
      repeat (2) @(negedge clock);
      chk("bp_pc", instr_pc, 32'h0800_0000);

      // run off the end of the ROM window
      do_branch(32'h080F_FFF0);
      repeat (6) @(negedge clock);
      chk("edge_valid", 32'(instr_valid), 32'd1);
      chk("edge_pc", instr_pc, 32'h080F_FFFC);
      chk("edge_instr", instr, 32'hE003_FFFF);
      chk("edge_fault", 32'(fetch_fault), 32'd1);
      chk("edge_addr_hold", rom_address, 32'h080F_FFFC);
      @(negedge clock);
      chk("fault_empty", 32'(instr_valid), 32'd0);
      repeat (3) @(negedge clock);
      chk("fault_sticky", 32'(fetch_fault), 32'd1);
      do_branch(32'h0800_0000);
      @(negedge clock);
      chk("fault_clear", 32'(fetch_fault), 32'd0);
      chk("resume_addr", rom_address, 32'h0800_0000);
      repeat (2) @(negedge clock);
      chk("resume_pc", instr_pc, 32'h0800_0000);

      // asynchronous reset with three entries buffered
      tick();
      branch_valid  = 1'b1;
      branch_target = 32'h0800_0040;
      instr_ready   = 1'b0;
      tick();
      branch_valid = 1'b0;
      repeat (4) tick();
      chk("mid_occ", 32'(dut.fifo_occ), 32'd3);
      chk("mid_valid_before", 32'(instr_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_valid_async", 32'(instr_valid), 32'd0);
      chk("mid_addr_async", rom_address, RV);
      chk("mid_fault_async", 32'(fetch_fault), 32'd0);
      repeat (2) tick();
      reset_n     = 1'b1;
      instr_ready = 1'b1;
      @(negedge clock); chk("restart_addr", rom_address, 32'h0800_0000);
      repeat (2) @(negedge clock);
      chk("restart_pc", instr_pc, 32'h0800_0000);
      repeat (5) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
